// File: rtl/mul_operand_prep_stage_if.sv
// mul_operand_prep_stage_if: producer/consumer handshake and data bundle for the operand-prep stage
interface mul_operand_prep_stage_if;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] operand_a, operand_b, mag_a, mag_b;
  logic [1:0] opcode, precision, opcode_out, precision_out;
  logic [3:0] sign_signal_a, sign_signal_b;
  modport slave (
    input  flush, in_valid, operand_a, operand_b, opcode, precision, out_ready,
    output in_ready, out_valid, mag_a, mag_b, sign_signal_a, sign_signal_b, opcode_out, precision_out
  );
  modport master (
    output flush, in_valid, operand_a, operand_b, opcode, precision, out_ready,
    input  in_ready, out_valid, mag_a, mag_b, sign_signal_a, sign_signal_b, opcode_out, precision_out
  );
endinterface

// File: rtl/mul_operand_prep_stage.sv
// mul_operand_prep_stage: per-element sign/magnitude prep ahead of the Vedic array, behind a 2-entry skid buffer
module mul_operand_prep_stage #(
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  mul_operand_prep_stage_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [1:0] opc;
    logic [1:0] prec;
    logic [3:0] sb;
    logic [3:0] sa;
    logic [DATA_W-1:0] mb;
    logic [DATA_W-1:0] ma;
  } beat_t;
  // Returns {slice signs, magnitude}; carries never cross element boundaries.
  function automatic logic [35:0] prep(input logic [31:0] x, input logic s, input logic [1:0] p);
    logic [31:0] m;
    logic [3:0] g;
    m = x;
    g = '0;
    if (p == 2'b10) begin
      g = {4{s & x[31]}};
      m = g[0] ? -x : x;
    end else if (p == 2'b01) begin
      for (int i = 0; i < 2; i++) begin
        g[2*i]   = s & x[16*i+15];
        g[2*i+1] = g[2*i];
        m[16*i +: 16] = g[2*i] ? -x[16*i +: 16] : x[16*i +: 16];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        g[i] = s & x[8*i+7];
        m[8*i +: 8] = g[i] ? -x[8*i +: 8] : x[8*i +: 8];
      end
    end
    return {g, m};
  endfunction
  state_t state_q, state_d;
  beat_t main_q, main_d, skid_q, skid_d, beat_in;
  logic in_ready_q, in_ready_d, out_valid, acc, pop;
  logic [35:0] pa, pb;
  always_comb begin
    pa = prep(bus.operand_a, bus.opcode != 2'b10, bus.precision);
    pb = prep(bus.operand_b, !bus.opcode[1], bus.precision);
    beat_in = {bus.opcode, bus.precision, pb[35:32], pa[35:32], pb[31:0], pa[31:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end
  always_comb begin
    out_valid = state_q != EMPTY;
    acc = bus.in_valid & in_ready_q;
    pop = out_valid & bus.out_ready;
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = acc ? ONE : EMPTY;
      ONE:     state_d = (acc & !pop) ? FULL : (pop & !acc) ? EMPTY : ONE;
      FULL:    state_d = pop ? ONE : FULL;
      default: state_d = EMPTY;
    endcase
    state_d = bus.flush ? EMPTY : state_d;
    in_ready_d = state_d != FULL;
    // In FULL in_ready is low, so acc only ever loads from EMPTY or ONE.
    main_d = (acc & (state_q == EMPTY | pop)) ? beat_in : (state_q == FULL & pop) ? skid_q : main_q;
    skid_d = (acc & state_q == ONE & !pop) ? beat_in : skid_q;
  end
  always_comb begin
    bus.out_valid     = out_valid;
    bus.in_ready      = in_ready_q;
    bus.mag_a         = main_q.ma;
    bus.mag_b         = main_q.mb;
    bus.sign_signal_a = main_q.sa;
    bus.sign_signal_b = main_q.sb;
    bus.opcode_out    = main_q.opc;
    bus.precision_out = main_q.prec;
  end
endmodule

// File: doc/mul_operand_prep_stage.md
# mul_operand_prep_stage

Registered operand-preparation stage directly upstream of the Vedic multiplier array in the vector multiplier datapath. It accepts two packed 32-bit vector operands with opcode and precision. Per element, it decides signedness, converts negative elements to magnitude, and produces the per-product-slice `sign_signal_a`/`sign_signal_b` vectors that the output two's-complement control stage consumes. A 2-entry skid buffer with valid/ready on both sides decouples the producer from the multiplier pipeline at full throughput.

## Interface
- `DATA_W`, 32: packed operand width. Fixed at 32; other values are unsupported.
- `clk`  in  1  clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `flush`  in  1  synchronous clear of all buffered entries.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `operand_a`  in  32  packed elements, multiplicand.
- `operand_b`  in  32  packed elements, multiplier.
- `opcode`  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU.
- `precision`  in  2  00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 8-bit.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `mag_a`  out  32  per-element magnitude of `operand_a`.
- `mag_b`  out  32  per-element magnitude of `operand_b`.
- `sign_signal_a`  out  4  operand-a sign per 16-bit product slice.
- `sign_signal_b`  out  4  operand-b sign per 16-bit product slice.
- `opcode_out`  out  2  opcode, passed through.
- `precision_out`  out  2  precision, passed through.

## Operation
- **Signedness per operand.**
  - opcode 00 or 01: a signed, b signed.
  - opcode 10: a unsigned, b unsigned.
  - opcode 11: a signed, b unsigned.
- **Element negative** when its operand is signed and the element MSB is 1. Element MSBs are:
  - 8-bit: bits 7, 15, 23, 31.
  - 16-bit: bits 15, 31.
  - 32-bit: bit 31.
- **Magnitude.** A negative element becomes its two's complement within the element width. A non-negative or unsigned element passes unchanged. The most-negative value maps to itself (0x80 → 0x80, read as unsigned 128). No carry crosses element boundaries.
- **Slice sign mapping.** Slice i is product bits 16i+15:16i.
  - 8-bit: slice i ← element i.
  - 16-bit: slices 0,1 ← element 0; slices 2,3 ← element 1.
  - 32-bit: slices 0–3 ← element 0.
- **Data path.** All computation is combinational on the input side. Results are captured into the buffer together with `opcode` and `precision`.
- **Buffer states.**
  - EMPTY: `out_valid`=0.
  - ONE: main register valid.
  - FULL: main and skid registers valid.
- **Transitions.** acc = `in_valid`&`in_ready`; pop = `out_valid`&`out_ready`.
  - EMPTY + acc → ONE.
  - ONE + acc & !pop → FULL, new beat into skid.
  - ONE + acc & pop → ONE, main register reloaded.
  - ONE + pop & !acc → EMPTY.
  - FULL + pop → ONE, skid moves to main.
- **Ordering.** Strict FIFO; beats are never dropped or duplicated.
- **Flush.** `flush` forces EMPTY on the next edge and discards any beat accepted in the same cycle. It has priority over acc and pop.

## Timing
- **Reset values.** `out_valid`=0, `in_ready`=1, all data outputs 0, state EMPTY. Asynchronous reset mid-transfer discards everything; the first post-reset accept is the next beat.
- **Latency.** A beat accepted at edge N is presented with `out_valid`=1 after edge N. Throughput is 1 beat/cycle while `out_ready`=1.
- **`in_ready`** is a register output, equal to !FULL. It has no combinational path from `out_ready`.
- **Output stability.** While `out_valid`=1 & `out_ready`=0, all outputs hold stable.
- **Pop and accept in FULL.** FULL + pop with `in_valid`: `in_ready` is 0 that cycle, so nothing is accepted. `in_ready` rises the following cycle.
- **Flush.** `flush` is synchronous. After the flushing edge: `out_valid`=0, `in_ready`=1.

## Test plan
- **8-bit MULH.** opcode=01, precision=00, a=0x80FF7F02, b=0x01010101 → mag_a=0x80017F02, sign_signal_a=4'b1100, mag_b=0x01010101, sign_signal_b=0000, one cycle after accept.
- **16-bit MULHU and MULSU.**
  - MULHU: a=0xFFFF8000, b=0x8000FFFF → magnitudes unchanged, both sign vectors 0000.
  - MULSU, same operands: mag_a=0x00018000, sign_signal_a=4'b1111, b unchanged, sign_signal_b=0000.
- **32-bit MULSU.** a=0xFFFFFFFE, b=0x80000000 → mag_a=0x00000002, sign_signal_a=1111, mag_b=0x80000000, sign_signal_b=0000.
- **Backpressure.** Hold `out_ready`=0 and drive beats B0, B1, B2 back-to-back → B0 and B1 accepted, `in_ready`=0 from the cycle after B1 is accepted, B2 held. Release `out_ready` → B0, B1, B2 emerge in order with no gaps after the first.
- **Flush.** In FULL state, pulse `flush` together with `in_valid` → next cycle `out_valid`=0, `in_ready`=1. No flushed beat appears afterwards.
- **Reset mid-stream.** Assert `rst_n`=0 asynchronously in ONE state → `out_valid` drops immediately, `in_ready`=1. After release, a streamed beat emerges with latency 1.
